bus_decoder: RTL

- Sits between the picorv32 native memory interface and the on-chip slaves: the firmware RAM controller and up to three peripherals.
- Decodes mem_addr and drives one active-high enable per slave. Samples the shared tri-stated ready/rdata lines.
- Returns a registered one-cycle mem_ready/mem_rdata to the CPU.
- Unmapped addresses and slaves that never answer are terminated with an error response and a sticky error flag, so the CPU never hangs.

---
 rtl/bus_decoder_pkg.sv | 29 ++
 rtl/bus_decoder_if.sv | 22 ++
 rtl/bus_decoder_timer.sv | 32 +++
 rtl/bus_decoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bus_decoder_pkg.sv
// Shared types and default address map for the picorv32 bus decoder.
package bus_pkg;

  localparam int NSLV = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] S0_MASK_DEF = 32'hFFFF_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'hFFFF_0000;
  localparam logic [31:0] S1_MASK_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] S2_BASE_DEF = 32'hFFFF_0100;
  localparam logic [31:0] S2_MASK_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] S3_BASE_DEF = 32'hFFFF_0200;
  localparam logic [31:0] S3_MASK_DEF = 32'hFFFF_FF00;

  // Keeps only the lowest set bit, so overlapping windows resolve to the lowest index.
  function automatic logic [NSLV-1:0] lowest_hit(input logic [NSLV-1:0] hits);
    return hits & ((~hits) + {{(NSLV-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// picorv32 native memory bus as seen between the CPU and the decoder.
interface bus_decoder_if;
  // Handshake: the CPU raises mem_valid with a stable address/strobe and holds it
  // until it samples mem_ready high; mem_ready is a single-cycle strobe and
  // mem_rdata is valid in that same cycle.
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_wstrb, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_wstrb, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/bus_decoder_timer.sv
// 8-bit access watchdog: clear beats load beats count; expired flags the last wait cycle.
module bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/bus_decoder.sv
// Address decoder and response register between picorv32 and four on-chip slaves.
module bus_decoder
  import bus_pkg::*;
#(
  parameter logic [31:0] S0_BASE   = S0_BASE_DEF,
  parameter logic [31:0] S0_MASK   = S0_MASK_DEF,
  parameter logic [31:0] S1_BASE   = S1_BASE_DEF,
  parameter logic [31:0] S1_MASK   = S1_MASK_DEF,
  parameter logic [31:0] S2_BASE   = S2_BASE_DEF,
  parameter logic [31:0] S2_MASK   = S2_MASK_DEF,
  parameter logic [31:0] S3_BASE   = S3_BASE_DEF,
  parameter logic [31:0] S3_MASK   = S3_MASK_DEF,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  bus_decoder_if.slave    bus,
  output logic [NSLV-1:0] slv_en,
  input  logic            slv_ready,
  input  logic [31:0]     slv_rdata,
  output logic            bus_err,
  output logic [31:0]     err_addr,
  input  logic            err_clr,
  output state_t          state
);

  state_t          state_q, state_d;
  logic [NSLV-1:0] hits, sel;
  logic [NSLV-1:0] slv_en_q, slv_en_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic            tmr_clr, tmr_load, tmr_en, tmr_expired;
  logic            unused_cpu;

  // Instruction/data and read/write are treated identically by the decoder.
  assign unused_cpu = ^{bus.mem_instr, bus.mem_wstrb};

  always_comb begin
    hits    = '0;
    hits[0] = (bus.mem_addr & S0_MASK) == S0_BASE;
    hits[1] = (bus.mem_addr & S1_MASK) == S1_BASE;
    hits[2] = (bus.mem_addr & S2_MASK) == S2_BASE;
    hits[3] = (bus.mem_addr & S3_MASK) == S3_BASE;
    sel     = lowest_hit(hits);
  end

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (8'd0),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      slv_en_q   <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      slv_en_q   <= slv_en_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slv_en_d   = slv_en_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q & ~err_clr;
    err_addr_d = err_addr_q;
    tmr_clr    = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (|hits) begin
            state_d  = ACCESS;
            slv_en_d = sel;
            tmr_load = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACCESS: begin
        // A withdrawn request is dropped silently rather than answered.
        if (!bus.mem_valid) begin
          state_d  = IDLE;
          slv_en_d = '0;
          tmr_clr  = 1'b1;
        end else if (slv_ready) begin
          state_d  = RESP;
          slv_en_d = '0;
          ready_d  = 1'b1;
          rdata_d  = slv_rdata;
          tmr_clr  = 1'b1;
        end else if (tmr_expired) begin
          state_d  = ERR;
          slv_en_d = '0;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ERR: begin
        // A new fault overrides a simultaneous err_clr.
        state_d    = RESP;
        ready_d    = 1'b1;
        rdata_d    = ERR_RDATA;
        err_d      = 1'b1;
        err_addr_d = bus.mem_addr;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        slv_en_d = '0;
      end
    endcase
  end

  assign slv_en        = slv_en_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus_err       = err_q;
  assign err_addr      = err_addr_q;
  assign state         = state_q;

endmodule
